// File: rtl/arbitro_memoria_datos_if.sv
// Bus bundle of the data memory arbiter. It carries the pipeline and debug
// request/response signals and the memory-side strobes and data.
// slave  : the arbiter's view.
// master : the view of the requesters and the memory.
interface arbitro_memoria_datos_if #(
  parameter int NBITS = 32
);
  // Pipeline MEM stage requester
  logic             i_PipeReq;
  logic             i_PipeWe;
  logic [NBITS-1:0] i_PipeDir;
  logic [NBITS-1:0] i_PipeDato;
  // Debug unit requester
  logic             i_DebugReq;
  logic             i_DebugWe;
  logic [NBITS-1:0] i_DebugDir;
  logic [NBITS-1:0] i_DebugDato;
  logic             i_DebugHalt;
  // Memory side
  logic [NBITS-1:0] i_DatoLeido;
  logic [NBITS-1:0] o_MemDireccion;
  logic [NBITS-1:0] o_MemDato;
  logic             o_MemRead;
  logic             o_MemWrite;
  // Responses
  logic             o_PipeAck;
  logic             o_DebugAck;
  logic [NBITS-1:0] o_DatoLeido;
  logic             o_StallPipeline;
  logic             o_Error;

  modport slave (
    input  i_PipeReq, i_PipeWe, i_PipeDir, i_PipeDato,
    input  i_DebugReq, i_DebugWe, i_DebugDir, i_DebugDato, i_DebugHalt,
    input  i_DatoLeido,
    output o_MemDireccion, o_MemDato, o_MemRead, o_MemWrite,
    output o_PipeAck, o_DebugAck, o_DatoLeido, o_StallPipeline, o_Error
  );

  modport master (
    output i_PipeReq, i_PipeWe, i_PipeDir, i_PipeDato,
    output i_DebugReq, i_DebugWe, i_DebugDir, i_DebugDato, i_DebugHalt,
    output i_DatoLeido,
    input  o_MemDireccion, o_MemDato, o_MemRead, o_MemWrite,
    input  o_PipeAck, o_DebugAck, o_DatoLeido, o_StallPipeline, o_Error
  );
endinterface

// File: rtl/arbitro_memoria_datos.sv
// arbitro_memoria_datos: shares the single-port data memory between the
// pipeline MEM stage (P) and the debug unit (D), one access at a time.
// Writes take 2 cycles (IDLE, ACCESS), reads take 3 (IDLE, ACCESS, RESP).
// Optional macro ARBITRO_ROUND_ROBIN_EN: on a P/D tie the requester not
// granted last wins. Without it, P always wins a tie.
module arbitro_memoria_datos #(
  parameter int NBITS  = 32,
  parameter int CELDAS = 10
) (
  input logic                    i_clk,
  input logic                    i_reset,
  arbitro_memoria_datos_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic             OWN_P  = 1'b0;
  localparam logic             OWN_D  = 1'b1;
  localparam logic [NBITS-1:0] LIMITE = NBITS'(CELDAS);

  state_t           state_q;
  logic             owner_q;
  logic             we_q;
  logic [NBITS-1:0] dir_q;
  logic [NBITS-1:0] dato_q;
  logic [NBITS-1:0] dato_leido_q;
  logic             mem_read_q;
  logic             mem_write_q;
  logic             pipe_ack_q;
  logic             debug_ack_q;
  logic             error_q;
`ifdef ARBITRO_ROUND_ROBIN_EN
  logic             last_owner_q;
`endif

  logic             p_elig;
  logic             d_elig;
  logic             win_d;
  logic             sel_we;
  logic             sel_err;
  logic [NBITS-1:0] sel_dir;
  logic [NBITS-1:0] sel_dato;

  // Pick the winner among eligible requesters and select its fields
  always_comb begin
    p_elig = bus.i_PipeReq && !bus.i_DebugHalt;
    d_elig = bus.i_DebugReq;
`ifdef ARBITRO_ROUND_ROBIN_EN
    win_d  = d_elig && (!p_elig || (last_owner_q == OWN_P));
`else
    win_d  = d_elig && !p_elig;
`endif
    sel_we   = win_d ? bus.i_DebugWe   : bus.i_PipeWe;
    sel_dir  = win_d ? bus.i_DebugDir  : bus.i_PipeDir;
    sel_dato = win_d ? bus.i_DebugDato : bus.i_PipeDato;
    sel_err  = (sel_dir >= LIMITE);
  end

  // Sequencer: grant, memory access and response, all outputs registered
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_P;
      we_q         <= 1'b0;
      dir_q        <= '0;
      dato_q       <= '0;
      dato_leido_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      pipe_ack_q   <= 1'b0;
      debug_ack_q  <= 1'b0;
      error_q      <= 1'b0;
`ifdef ARBITRO_ROUND_ROBIN_EN
      last_owner_q <= OWN_D;
`endif
    end else begin
      // Strobes, acks and error are single-cycle unless set below
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      pipe_ack_q  <= 1'b0;
      debug_ack_q <= 1'b0;
      error_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (p_elig || d_elig) begin
            owner_q <= win_d;
            we_q    <= sel_we;
            dir_q   <= sel_dir;
            dato_q  <= sel_dato;
            state_q <= ACCESS;
`ifdef ARBITRO_ROUND_ROBIN_EN
            last_owner_q <= win_d;
`endif
            if (sel_err) begin
              // Out of range: no strobe, acknowledge right away with error
              error_q     <= 1'b1;
              pipe_ack_q  <= !win_d;
              debug_ack_q <= win_d;
              if (!sel_we) begin
                dato_leido_q <= '0;
              end
            end else begin
              mem_write_q <= sel_we;
              mem_read_q  <= !sel_we;
              // A write completes in the ACCESS cycle itself
              if (sel_we) begin
                pipe_ack_q  <= !win_d;
                debug_ack_q <= win_d;
              end
            end
          end
        end
        ACCESS: begin
          if (!error_q && !we_q) begin
            state_q     <= RESP;
            pipe_ack_q  <= (owner_q == OWN_P);
            debug_ack_q <= (owner_q == OWN_D);
          end else begin
            state_q <= IDLE;
          end
        end
        RESP: begin
          dato_leido_q <= bus.i_DatoLeido;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are dropped while reset is high so a pending write never lands
  assign bus.o_MemRead       = mem_read_q && !i_reset;
  assign bus.o_MemWrite      = mem_write_q && !i_reset;
  assign bus.o_MemDireccion  = dir_q;
  assign bus.o_MemDato       = dato_q;
  assign bus.o_PipeAck       = pipe_ack_q;
  assign bus.o_DebugAck      = debug_ack_q;
  assign bus.o_Error         = error_q;
  // Read data passes straight through in RESP and is held afterwards
  assign bus.o_DatoLeido     = (state_q == RESP) ? bus.i_DatoLeido : dato_leido_q;
  assign bus.o_StallPipeline = bus.i_PipeReq && !pipe_ack_q;

endmodule
